// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the ALU execution sequencer: opcodes, ALU selects,
// FSM states and default widths.
package alu_exec_sequencer_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_REG_ADDR_W = 3;

    localparam logic [2:0] OP_LOADI = 3'd0;
    localparam logic [2:0] OP_MOV   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;

    localparam logic [2:0] SEL_FWD = 3'b000;
    localparam logic [2:0] SEL_ADD = 3'b001;
    localparam logic [2:0] SEL_AND = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_e;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// Instruction handshake, ALU operand/result and debug-read bundle.
// slave = sequencer view, master = decode/ALU/debug environment view.
interface alu_exec_sequencer_if
    import alu_exec_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
);
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [2:0]            IN_OPCODE;
    logic [REG_ADDR_W-1:0] IN_DEST;
    logic [REG_ADDR_W-1:0] IN_SRC1;
    logic [REG_ADDR_W-1:0] IN_SRC2;
    logic [DATA_W-1:0]     IN_IMM;
    logic [DATA_W-1:0]     ALU_DATA1;
    logic [DATA_W-1:0]     ALU_DATA2;
    logic [2:0]            ALU_SELECT;
    logic [DATA_W-1:0]     ALU_RESULT;
    logic                  DONE;
    logic                  ILLEGAL;
    logic [REG_ADDR_W-1:0] DBG_ADDR;
    logic [DATA_W-1:0]     DBG_DATA;

    modport slave (
        input  IN_VALID, IN_OPCODE, IN_DEST, IN_SRC1, IN_SRC2, IN_IMM,
        input  ALU_RESULT, DBG_ADDR,
        output IN_READY, ALU_DATA1, ALU_DATA2, ALU_SELECT, DONE, ILLEGAL, DBG_DATA
    );

    modport master (
        output IN_VALID, IN_OPCODE, IN_DEST, IN_SRC1, IN_SRC2, IN_IMM,
        output ALU_RESULT, DBG_ADDR,
        input  IN_READY, ALU_DATA1, ALU_DATA2, ALU_SELECT, DONE, ILLEGAL, DBG_DATA
    );

endinterface

// File: rtl/alu_exec_sequencer_reg_file_8x8.sv
// Register file: two combinational read ports, one debug read port,
// one synchronous write port, asynchronous clear.
module reg_file_8x8 #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0]     rd1_data,
    input  logic [REG_ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0]     rd2_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage: cleared on reset, single write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: purely combinational
    always_comb begin
        rd1_data = regs[rd1_addr];
        rd2_data = regs[rd2_addr];
        dbg_data = regs[dbg_addr];
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle sequencer in front of the external 8-bit ALU: accepts an
// instruction, drives ALU operands for the op-dependent settle time, then
// writes the ALU result back to the destination register.
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned ADD_WAIT   = 2,
    parameter int unsigned LOGIC_WAIT = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    alu_exec_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     data1_q, data1_d;
    logic [DATA_W-1:0]     data2_q, data2_d;
    logic [2:0]            sel_q, sel_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_W-1:0]     rd1, rd2;
    logic                  wb_en;

    reg_file_8x8 #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regs (
        .clk      (CLK),
        .rst      (RESET),
        .rd1_addr (bus.IN_SRC1),
        .rd1_data (rd1),
        .rd2_addr (bus.IN_SRC2),
        .rd2_data (rd2),
        .dbg_addr (bus.DBG_ADDR),
        .dbg_data (bus.DBG_DATA),
        .we       (wb_en),
        .waddr    (dest_q),
        .wdata    (bus.ALU_RESULT)
    );

    // State and held ALU operands; reset abandons any in-flight instruction
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dest_q    <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            sel_q     <= SEL_FWD;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dest_q    <= dest_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            sel_q     <= sel_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state: operands are captured at acceptance and held through EXEC/WB
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        sel_d     = sel_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.IN_VALID) begin
                    if (!is_legal(bus.IN_OPCODE)) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        dest_d  = bus.IN_DEST;
                        data1_d = rd1;
                        data2_d = rd2;
                        sel_d   = SEL_FWD;
                        case (bus.IN_OPCODE)
                            OP_LOADI: begin
                                data1_d = '0;
                                data2_d = bus.IN_IMM;
                            end
                            OP_MOV:  data1_d = '0;
                            OP_ADD:  sel_d = SEL_ADD;
                            OP_SUB: begin
                                data2_d = ~rd2 + DATA_W'(1);
                                sel_d   = SEL_ADD;
                            end
                            OP_AND:  sel_d = SEL_AND;
                            default: sel_d = SEL_OR;
                        endcase
                        cnt_d = (sel_d == SEL_ADD) ? CNT_W'(ADD_WAIT) : CNT_W'(LOGIC_WAIT);
                    end
                end
            end
            ST_EXEC: begin
                // Counter holds the remaining EXEC cycles including this one
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_WB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        wb_en          = (state_q == ST_WB);
        bus.IN_READY   = (state_q == ST_IDLE);
        bus.DONE       = (state_q == ST_WB);
        bus.ILLEGAL    = illegal_q;
        bus.ALU_DATA1  = data1_q;
        bus.ALU_DATA2  = data2_q;
        bus.ALU_SELECT = sel_q;
    end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execution front-end sitting on the far side of the 8-bit ALU's operand/result interface.
- Accepts decoded instructions over a valid/ready handshake and reads source operands from an internal register file.
- Drives the ALU's DATA1/DATA2/SELECT, waits the op-dependent ALU settle time, then captures the result and writes it back to the destination register.
- Sits between instruction decode and the ALU in the lab processor datapath.

Parameters:
- DATA_W, 8, operand/result width
- REG_ADDR_W, 3, register address width (8 registers)
- ADD_WAIT, 2, clock cycles to hold operands for ALU SELECT=001 (add)
- LOGIC_WAIT, 1, clock cycles to hold operands for SELECT=000/010/011

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  instruction present
- IN_READY  out  1  sequencer can accept an instruction
- IN_OPCODE  in  3  0=loadi, 1=mov, 2=add, 3=sub, 4=and, 5=or, 6/7=illegal
- IN_DEST  in  REG_ADDR_W  destination register
- IN_SRC1  in  REG_ADDR_W  source 1 register
- IN_SRC2  in  REG_ADDR_W  source 2 register
- IN_IMM  in  DATA_W  immediate (loadi only)
- ALU_DATA1  out  DATA_W  operand to ALU DATA1
- ALU_DATA2  out  DATA_W  operand to ALU DATA2
- ALU_SELECT  out  3  ALU function select
- ALU_RESULT  in  DATA_W  ALU result
- DONE  out  1  one-cycle pulse when write-back occurs
- ILLEGAL  out  1  one-cycle pulse when an illegal opcode is accepted
- DBG_ADDR  in  REG_ADDR_W  debug read address
- DBG_DATA  out  DATA_W  combinational read of register DBG_ADDR

Behaviour:
- Reset (asynchronous, CLK-independent):
  - all 8 registers = 0; FSM = IDLE; IN_READY = 1.
  - ALU_DATA1 = ALU_DATA2 = 0; ALU_SELECT = 000; DONE = ILLEGAL = 0.
- Handshake: an instruction is accepted on a rising edge with IN_VALID && IN_READY.
  - IN_READY = 1 only in IDLE.
  - Instruction fields are latched at acceptance; input changes afterwards are ignored.
- FSM states: IDLE, EXEC, WB.
- IDLE -> EXEC on acceptance of a legal opcode. On that edge, load ALU outputs as follows:
  - loadi: DATA2 = IN_IMM, SELECT = 000.
  - mov: DATA2 = R[SRC2], SELECT = 000.
  - add: DATA1 = R[SRC1], DATA2 = R[SRC2], SELECT = 001.
  - sub: DATA1 = R[SRC1], DATA2 = (~R[SRC2] + 1) mod 2^DATA_W, SELECT = 001.
  - and: DATA1 = R[SRC1], DATA2 = R[SRC2], SELECT = 010.
  - or: DATA1 = R[SRC1], DATA2 = R[SRC2], SELECT = 011.
  - DATA1 for loadi/mov is don't-care; drive 0.
- Operand read: register values are sampled at the acceptance edge. SRC1 == SRC2 == DEST is legal.
- Illegal opcode: accepted (handshake completes); ILLEGAL pulses on the next cycle; FSM stays IDLE; no register write.
- EXEC: a wait counter is loaded with ADD_WAIT for SELECT=001 and LOGIC_WAIT otherwise.
  - Counter decrements each cycle; ALU outputs are held stable.
  - Move to WB after the counter reaches 0 (ADD_WAIT=2 gives 2 cycles in EXEC).
- WB (one cycle):
  - R[DEST] <= ALU_RESULT on the WB rising edge; DONE = 1 during WB.
  - Return to IDLE.
- Latency: acceptance to DONE = wait + 1 cycles (add/sub: 3, others: 2). Throughput: one instruction per latency + 1 cycles.
- Arithmetic: all wrap modulo 2^DATA_W; no flags. sub of 0x05 - 0x07 = 0xFE.
- DBG_DATA is a combinational register read and reflects a write from the clock edge after that write.
- Simultaneous events: IN_VALID asserted during EXEC/WB is ignored (IN_READY = 0); the source must hold it.
- Reset mid-operation: the in-flight instruction is abandoned with no write-back and no DONE; all registers are cleared.

Decomposition:
- Shared package:
  - opcode constants (OP_LOADI..OP_OR);
  - ALU select constants (SEL_FWD=000, SEL_ADD=001, SEL_AND=010, SEL_OR=011);
  - FSM state encoding;
  - DATA_W / REG_ADDR_W defaults.
- Sub-module reg_file_8x8:
  - two combinational read ports plus a debug read port;
  - one synchronous write port;
  - asynchronous active-high clear on RESET.
- The ALU itself is external; benches instantiate it beside the sequencer.

Test Plan:
- Reset then DBG reads of addresses 0..7 -> all 0x00; IN_READY = 1.
- loadi R1 = 0x05, loadi R2 = 0x07, add R3 = R1 + R2 -> ALU_SELECT = 001 held for 2 cycles; DONE 3 cycles after acceptance; DBG R3 = 0x0C.
- sub R4 = R1 - R2 -> ALU_DATA2 = 0xF9; R4 = 0xFE. add 0xFF + 0x02 -> 0x01 (wrap).
- and R5 = 0xF0 & 0x3C -> 0x30; or R6 -> 0xFC; mov R7 = R6 -> 0xFC. Each gives DONE 2 cycles after acceptance.
- IN_VALID held high with changing fields during EXEC -> no extra acceptance; next instruction is taken only once IN_READY returns high.
- Opcode 7 -> ILLEGAL pulse, no register change. RESET asserted mid-add -> no DONE, all registers 0, IN_READY = 1 immediately.
